// File: rtl/r5p_htif_if.sv
// TCB load/store bus: single-beat request, read data returned one cycle after the transfer.
interface tcb_if;
    typedef struct packed {
        logic        wen;
        logic [31:0] adr;
        logic [3:0]  ben;
        logic [31:0] wdt;
    } req_t;

    typedef struct packed {
        logic [31:0] rdt;
    } rsp_t;

    logic vld;
    logic rdy;
    req_t req;
    rsp_t rsp;

    modport man (output vld, output req, input rdy, input rsp);
    modport sub (input vld, input req, output rdy, output rsp);
endinterface

// File: rtl/r5p_htif.sv
// HTIF responder: tohost/fromhost register pair on TCB, executing exit and console commands.
//
// state | meaning
// IDLE  | waiting for a tohost high-word write
// EXEC  | decoding device/command of tohost
// PUTC  | presenting a character to the console sink
// GETC  | requesting a character from the console source
// RESP  | waiting for fromhost to be free, then posting the response
// HALT  | exit command received; terminal until reset
module r5p_htif #(
    parameter logic [31:0] ADR_TOH = 32'h8000_1000,
    parameter logic [31:0] ADR_FRH = 32'h8000_1040
)(
    input  logic        clk,
    input  logic        rst,
    tcb_if.sub          tcb,
    output logic        con_tx_vld,
    input  logic        con_tx_rdy,
    output logic [7:0]  con_tx_dat,
    input  logic        con_rx_vld,
    output logic        con_rx_rdy,
    input  logic [7:0]  con_rx_dat,
    output logic        halt,
    output logic [30:0] exit_code,
    output logic        bsy,
    output logic        err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXEC,
        ST_PUTC,
        ST_GETC,
        ST_RESP,
        ST_HALT
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] toh_q, toh_d;
    logic [63:0] frh_q, frh_d;
    logic [63:0] rsp_q, rsp_d;
    logic [7:0]  chr_q, chr_d;
    logic [30:0] exit_q, exit_d;
    logic        err_q, err_d;
    logic [31:0] rdt_q, rdt_d;

    logic        trn;
    logic        hit_toh;
    logic        hit_frh;
    logic        hi;
    logic        wr_toh;
    logic        wr_frh;
    logic        rd;
    logic [7:0]  dev;
    logic [7:0]  cmd;
    logic        unused_adr;

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] wdt,
                                          input logic [3:0]  ben);
        logic [31:0] res;
        res = old;
        for (int i = 0; i < 4; i++) begin
            if (ben[i]) res[i*8 +: 8] = wdt[i*8 +: 8];
        end
        return res;
    endfunction

    assign unused_adr = ^tcb.req.adr[1:0];

    assign trn     = tcb.vld & ~rst;
    assign hit_toh = (tcb.req.adr[31:3] == ADR_TOH[31:3]);
    assign hit_frh = (tcb.req.adr[31:3] == ADR_FRH[31:3]);
    assign hi      = tcb.req.adr[2];
    assign wr_toh  = trn &  tcb.req.wen & hit_toh;
    assign wr_frh  = trn &  tcb.req.wen & hit_frh;
    assign rd      = trn & ~tcb.req.wen;
    assign dev     = toh_q[63:56];
    assign cmd     = toh_q[55:48];

    always_comb begin
        state_d = state_q;
        toh_d   = toh_q;
        frh_d   = frh_q;
        rsp_d   = rsp_q;
        chr_d   = chr_q;
        exit_d  = exit_q;
        err_d   = err_q;
        rdt_d   = 32'd0;

        // reads see register contents from before this edge's updates
        if (rd) begin
            if (hit_toh)      rdt_d = hi ? toh_q[63:32] : toh_q[31:0];
            else if (hit_frh) rdt_d = hi ? frh_q[63:32] : frh_q[31:0];
        end

        if (wr_frh) begin
            if (hi) frh_d[63:32] = merge(frh_q[63:32], tcb.req.wdt, tcb.req.ben);
            else    frh_d[31:0]  = merge(frh_q[31:0],  tcb.req.wdt, tcb.req.ben);
        end

        if (wr_toh) begin
            if (state_q != ST_IDLE) begin
                err_d = 1'b1;
            end else if (hi) begin
                toh_d[63:32] = merge(toh_q[63:32], tcb.req.wdt, tcb.req.ben);
                state_d      = ST_EXEC;
            end else begin
                toh_d[31:0]  = merge(toh_q[31:0], tcb.req.wdt, tcb.req.ben);
            end
        end

        case (state_q)
            ST_EXEC: begin
                if (dev == 8'd0 && cmd == 8'd0 && toh_q[0]) begin
                    exit_d  = toh_q[31:1];
                    state_d = ST_HALT;
                end else if (dev == 8'd1 && cmd == 8'd1) begin
                    chr_d   = toh_q[7:0];
                    state_d = ST_PUTC;
                end else if (dev == 8'd1 && cmd == 8'd0) begin
                    state_d = ST_GETC;
                end else begin
                    err_d   = 1'b1;
                    toh_d   = 64'd0;
                    state_d = ST_IDLE;
                end
            end
            ST_PUTC: begin
                if (con_tx_rdy) begin
                    toh_d   = 64'd0;
                    rsp_d   = {8'd1, 8'd1, 48'd0};
                    state_d = ST_RESP;
                end
            end
            ST_GETC: begin
                if (con_rx_vld) begin
                    toh_d   = 64'd0;
                    rsp_d   = {8'd1, 8'd0, 40'd0, con_rx_dat};
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                // a same-cycle software write to fromhost takes precedence
                if (frh_q == 64'd0 && !wr_frh) begin
                    frh_d   = rsp_q;
                    state_d = ST_IDLE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            toh_q   <= 64'd0;
            frh_q   <= 64'd0;
            rsp_q   <= 64'd0;
            chr_q   <= 8'd0;
            exit_q  <= 31'd0;
            err_q   <= 1'b0;
            rdt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            toh_q   <= toh_d;
            frh_q   <= frh_d;
            rsp_q   <= rsp_d;
            chr_q   <= chr_d;
            exit_q  <= exit_d;
            err_q   <= err_d;
            rdt_q   <= rdt_d;
        end
    end

    assign tcb.rdy     = 1'b1;
    assign tcb.rsp.rdt = rdt_q;
    assign con_tx_vld  = (state_q == ST_PUTC);
    assign con_tx_dat  = con_tx_vld ? chr_q : 8'd0;
    assign con_rx_rdy  = (state_q == ST_GETC);
    assign halt        = (state_q == ST_HALT);
    assign exit_code   = exit_q;
    assign bsy         = (state_q != ST_IDLE);
    assign err         = err_q;

endmodule
